// File: rtl/reset_sequencer.sv
// rtl/reset_sequencer.sv - releases NUM_STAGES domain resets one at a time, each gated on the previous domain's done
module reset_sequencer #(
    parameter int NUM_STAGES  = 4,
    parameter int MIN_ASSERT  = 8,
    parameter int HOLD_CYCLES = 16,
    parameter int TIMEOUT     = 255
) (
    input  logic                          clk_i,
    input  logic                          rstn_i,
    input  logic                          soft_rst_i,
    input  logic [NUM_STAGES-1:0]         stage_done_i,
    output logic [NUM_STAGES-1:0]         rstn_o,
    output logic [$clog2(NUM_STAGES)-1:0] stage_idx_o,
    output logic                          busy_o,
    output logic                          all_ready_o,
    output logic                          timeout_o
);

    localparam int MAX_AH  = (MIN_ASSERT > HOLD_CYCLES) ? MIN_ASSERT : HOLD_CYCLES;
    localparam int MAX_CNT = (MAX_AH > TIMEOUT) ? MAX_AH : TIMEOUT;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);
    localparam int IDX_W   = $clog2(NUM_STAGES);

    localparam logic [CNT_W-1:0]      ASSERT_LAST = CNT_W'(MIN_ASSERT - 1);
    localparam logic [CNT_W-1:0]      HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0]      TO_LAST     = CNT_W'(TIMEOUT - 1);
    localparam logic [IDX_W-1:0]      IDX_LAST    = IDX_W'(NUM_STAGES - 1);
    localparam logic [NUM_STAGES-1:0] STAGE0      = NUM_STAGES'(1);

    typedef enum logic [1:0] {
        ST_ASSERT,
        ST_WAIT_DONE,
        ST_GAP,
        ST_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [NUM_STAGES-1:0]   rel_q, rel_d;
    logic                    busy_q, busy_d;
    logic                    ready_q, ready_d;
    logic                    tmo_q, tmo_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        rel_d   = rel_q;
        tmo_d   = tmo_q;

        // Soft reset outranks everything, including a done on the same edge;
        // the timeout flag survives it so software can still see a past miss.
        if (soft_rst_i) begin
            state_d = ST_ASSERT;
            cnt_d   = '0;
            idx_d   = '0;
            rel_d   = '0;
        end else begin
            unique case (state_q)
                ST_ASSERT: begin
                    rel_d = '0;
                    if (cnt_q == ASSERT_LAST) begin
                        rel_d   = STAGE0;
                        idx_d   = '0;
                        cnt_d   = '0;
                        state_d = ST_WAIT_DONE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_WAIT_DONE: begin
                    if (stage_done_i[idx_q] || (cnt_q == TO_LAST)) begin
                        if (!stage_done_i[idx_q]) begin
                            tmo_d = 1'b1;
                        end
                        cnt_d   = '0;
                        state_d = (idx_q == IDX_LAST) ? ST_DONE : ST_GAP;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_GAP: begin
                    if (cnt_q == HOLD_LAST) begin
                        idx_d   = idx_q + IDX_W'(1);
                        rel_d   = rel_q | (STAGE0 << idx_d);
                        cnt_d   = '0;
                        state_d = ST_WAIT_DONE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    rel_d = '1;
                end
                default: begin
                    state_d = ST_ASSERT;
                    cnt_d   = '0;
                    idx_d   = '0;
                    rel_d   = '0;
                end
            endcase
        end

        busy_d  = (state_d != ST_DONE);
        ready_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= ST_ASSERT;
            cnt_q   <= '0;
            idx_q   <= '0;
            rel_q   <= '0;
            busy_q  <= 1'b1;
            ready_q <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            rel_q   <= rel_d;
            busy_q  <= busy_d;
            ready_q <= ready_d;
            tmo_q   <= tmo_d;
        end
    end

    assign rstn_o      = rel_q;
    assign stage_idx_o = idx_q;
    assign busy_o      = busy_q;
    assign all_ready_o = ready_q;
    assign timeout_o   = tmo_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// tb/tb_reset_sequencer.sv - randomized bench for reset_sequencer against an edge-time model
module tb_reset_sequencer;

    localparam int N     = 4;
    localparam int MA    = 8;
    localparam int HC    = 16;
    localparam int TO    = 255;
    localparam int IW    = $clog2(N);
    localparam int NEVER = 100000;

    logic          clk = 1'b0;
    logic          rstn_i = 1'b0;
    logic          soft_rst_i = 1'b0;
    logic [N-1:0]  stage_done_i = '0;
    logic [N-1:0]  rstn_o;
    logic [IW-1:0] stage_idx_o;
    logic          busy_o;
    logic          all_ready_o;
    logic          timeout_o;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    reset_sequencer #(
        .NUM_STAGES (N),
        .MIN_ASSERT (MA),
        .HOLD_CYCLES(HC),
        .TIMEOUT    (TO)
    ) dut (
        .clk_i       (clk),
        .rstn_i      (rstn_i),
        .soft_rst_i  (soft_rst_i),
        .stage_done_i(stage_done_i),
        .rstn_o      (rstn_o),
        .stage_idx_o (stage_idx_o),
        .busy_o      (busy_o),
        .all_ready_o (all_ready_o),
        .timeout_o   (timeout_o)
    );

    // Domain k is released at edge r[k]; its done is first seen at r[k]+d[k],
    // it is left after min(d[k], TO) edges, and the next release follows HC edges later.
    task automatic drive_sequence(input int d[N], input int stop_at, input bit tmo_prev,
                                  input bit garb_ones, input string tag,
                                  output int rise[N], output bit tmo_out);
        int r[N];
        int e[N];
        int tmo_edge;
        int limit;
        int nrel;
        logic [N-1:0]  exp_rel;
        logic [IW-1:0] exp_idx;
        bit exp_ready;
        bit exp_tmo;
        tmo_edge = -1;
        exp_tmo  = tmo_prev;
        r[0] = MA;
        for (int k = 0; k < N; k++) begin
            e[k] = r[k] + ((d[k] <= TO) ? d[k] : TO);
            if (d[k] > TO && tmo_edge < 0) tmo_edge = e[k];
            if (k < N - 1) r[k+1] = e[k] + HC;
        end
        limit = (stop_at > 0) ? stop_at : e[N-1] + 4;
        for (int k = 0; k < N; k++) begin
            rise[k] = -1;
            stage_done_i[k] = garb_ones ? 1'b1 : 1'($urandom_range(0, 1));
        end
        for (int n = 1; n <= limit; n++) begin
            @(posedge clk);
            #1;
            nrel = 0;
            exp_rel = '0;
            for (int k = 0; k < N; k++) begin
                if (n >= r[k]) begin
                    exp_rel[k] = 1'b1;
                    nrel++;
                end
            end
            exp_idx   = IW'((nrel > 0) ? nrel - 1 : 0);
            exp_ready = (n >= e[N-1]);
            exp_tmo   = tmo_prev || (tmo_edge >= 0 && n >= tmo_edge);
            checks += 5;
            if (rstn_o !== exp_rel) begin
                failures++;
                $display("FAIL %s edge %0d rstn_o got %b exp %b", tag, n, rstn_o, exp_rel);
            end
            if (stage_idx_o !== exp_idx) begin
                failures++;
                $display("FAIL %s edge %0d stage_idx_o got %0d exp %0d", tag, n, stage_idx_o, exp_idx);
            end
            if (all_ready_o !== exp_ready) begin
                failures++;
                $display("FAIL %s edge %0d all_ready_o got %b exp %b", tag, n, all_ready_o, exp_ready);
            end
            if (busy_o !== !exp_ready) begin
                failures++;
                $display("FAIL %s edge %0d busy_o got %b exp %b", tag, n, busy_o, !exp_ready);
            end
            if (timeout_o !== exp_tmo) begin
                failures++;
                $display("FAIL %s edge %0d timeout_o got %b exp %b", tag, n, timeout_o, exp_tmo);
            end
            for (int k = 0; k < N; k++) begin
                if (rstn_o[k] === 1'b1 && rise[k] < 0) rise[k] = n;
                if (rise[k] >= 0) stage_done_i[k] = (n + 1 >= rise[k] + d[k]);
                else stage_done_i[k] = garb_ones ? 1'b1 : 1'($urandom_range(0, 1));
            end
        end
        tmo_out = exp_tmo;
    endtask

    task automatic pulse_soft(input int len, input bit tmo_exp, input string tag);
        soft_rst_i = 1'b1;
        for (int i = 0; i < len; i++) begin
            @(posedge clk);
            #1;
            checks += 4;
            if (rstn_o !== '0) begin
                failures++;
                $display("FAIL %s soft cycle %0d rstn_o got %b exp 0", tag, i, rstn_o);
            end
            if (stage_idx_o !== '0 || busy_o !== 1'b1) begin
                failures++;
                $display("FAIL %s soft cycle %0d idx/busy got %0d/%b exp 0/1", tag, i, stage_idx_o, busy_o);
            end
            if (all_ready_o !== 1'b0) begin
                failures++;
                $display("FAIL %s soft cycle %0d all_ready_o got %b exp 0", tag, i, all_ready_o);
            end
            if (timeout_o !== tmo_exp) begin
                failures++;
                $display("FAIL %s soft cycle %0d timeout_o got %b exp %b", tag, i, timeout_o, tmo_exp);
            end
        end
        soft_rst_i = 1'b0;
    endtask

    task automatic pulse_rstn(input string tag);
        @(negedge clk);
        rstn_i = 1'b0;
        #1;
        checks += 3;
        if (rstn_o !== '0) begin
            failures++;
            $display("FAIL %s async rstn_o got %b exp 0", tag, rstn_o);
        end
        if (stage_idx_o !== '0 || busy_o !== 1'b1 || all_ready_o !== 1'b0) begin
            failures++;
            $display("FAIL %s async idx/busy/ready got %0d/%b/%b exp 0/1/0", tag, stage_idx_o, busy_o, all_ready_o);
        end
        if (timeout_o !== 1'b0) begin
            failures++;
            $display("FAIL %s async timeout_o got %b exp 0", tag, timeout_o);
        end
        #1;
        rstn_i = 1'b1;
    endtask

    task automatic check_nominal_edges(input int rise[N], input string tag);
        int golden[N];
        golden = '{8, 25, 42, 59};
        for (int k = 0; k < N; k++) begin
            checks++;
            if (rise[k] !== golden[k]) begin
                failures++;
                $display("FAIL %s rise edge stage %0d got %0d exp %0d", tag, k, rise[k], golden[k]);
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) begin
            @(posedge clk);
            #1;
            checks++;
            if (rstn_o !== '0 || stage_idx_o !== '0 || busy_o !== 1'b1 ||
                all_ready_o !== 1'b0 || timeout_o !== 1'b0) begin
                failures++;
                $display("FAIL reset outputs got rstn=%b idx=%0d busy=%b ready=%b tmo=%b exp 0/0/1/0/0",
                         rstn_o, stage_idx_o, busy_o, all_ready_o, timeout_o);
            end
        end
        @(negedge clk);
        rstn_i = 1'b1;
    endtask

    task automatic test_nominal();
        int  rise[N];
        bit  tmo;
        drive_sequence('{1, 1, 1, 1}, 0, 1'b0, 1'b0, "nominal", rise, tmo);
        check_nominal_edges(rise, "nominal");
    endtask

    task automatic test_async_reset();
        int  rise[N];
        bit  tmo;
        pulse_rstn("async_in_done");
        drive_sequence('{1, 1, 1, 1}, 0, 1'b0, 1'b0, "async_rerun", rise, tmo);
        check_nominal_edges(rise, "async_rerun");
    endtask

    task automatic test_timeout();
        int  rise[N];
        bit  tmo;
        pulse_rstn("timeout_pre");
        drive_sequence('{1, NEVER, 1, 1}, 0, 1'b0, 1'b0, "timeout", rise, tmo);
        checks += 3;
        if (rise[1] !== 25) begin
            failures++;
            $display("FAIL timeout stage1 rise got %0d exp 25", rise[1]);
        end
        if (rise[2] !== 25 + 255 + 16) begin
            failures++;
            $display("FAIL timeout stage2 rise got %0d exp %0d", rise[2], 25 + 255 + 16);
        end
        if (timeout_o !== 1'b1) begin
            failures++;
            $display("FAIL timeout final flag got %b exp 1", timeout_o);
        end
    endtask

    task automatic test_soft_in_gap();
        int  rise[N];
        bit  tmo;
        pulse_soft(1, 1'b1, "soft_restart");
        drive_sequence('{1, 1, 1, 1}, 30, 1'b1, 1'b0, "soft_gap_pre", rise, tmo);
        pulse_soft(3, tmo, "soft_gap");
        drive_sequence('{1, 1, 1, 1}, 0, tmo, 1'b0, "soft_gap_post", rise, tmo);
        check_nominal_edges(rise, "soft_gap_post");
    endtask

    task automatic test_early_done();
        int  rise[N];
        bit  tmo;
        pulse_rstn("early_pre");
        drive_sequence('{40, 1, 1, 1}, 0, 1'b0, 1'b1, "early_done", rise, tmo);
        pulse_rstn("early_to_pre");
        drive_sequence('{NEVER, 1, 1, 1}, 0, 1'b0, 1'b1, "early_timeout", rise, tmo);
    endtask

    task automatic test_soft_same_edge();
        int  rise[N];
        bit  tmo;
        pulse_rstn("same_edge_pre");
        drive_sequence('{1, 1, 1, 1}, 42, 1'b0, 1'b0, "same_edge_pre", rise, tmo);
        checks++;
        if (stage_done_i[2] !== 1'b1) begin
            failures++;
            $display("FAIL same_edge done setup got %b exp 1", stage_done_i[2]);
        end
        pulse_soft(1, 1'b0, "same_edge");
        drive_sequence('{1, 1, 1, 1}, 0, 1'b0, 1'b0, "same_edge_post", rise, tmo);
        check_nominal_edges(rise, "same_edge_post");
    endtask

    task automatic test_random();
        int  rise[N];
        int  d[N];
        bit  tmo;
        int  stop;
        bit  garb;
        pulse_rstn("random_pre");
        tmo = 1'b0;
        for (int it = 0; it < 6; it++) begin
            for (int k = 0; k < N; k++) begin
                d[k] = ($urandom_range(0, 4) == 0) ? $urandom_range(TO - 2, TO + 40)
                                                   : $urandom_range(1, 30);
            end
            garb = 1'($urandom_range(0, 1));
            stop = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 150) : 0;
            if (stop > 0) begin
                drive_sequence(d, stop, tmo, garb, "random_part", rise, tmo);
                pulse_soft($urandom_range(1, 4), tmo, "random_soft");
            end
            drive_sequence(d, 0, tmo, garb, "random_full", rise, tmo);
            pulse_soft(1, tmo, "random_restart");
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_async_reset();
        test_timeout();
        test_soft_in_gap();
        test_early_done();
        test_soft_same_edge();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
